// File: rtl/spi_slave_sync.sv
// SPI responder that runs entirely in the clk domain: sclk/cs/mosi are oversampled and edges detected.
// Define SPI_SLAVE_SYNC_STATUS_EN to add sticky rx_overrun/tx_underrun status with rx_ack and status_clr.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_pin,
    input  logic                  cs_pin,
    input  logic                  mosi_pin,
    output logic                  miso_pin,
    output logic                  miso_oe,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    ,
    output logic [1:0]            status,
    input  logic                  status_clr,
    input  logic                  rx_ack
`endif
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Input synchronizers plus edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   cs_hist_q,   cs_hist_d;

    // Frame state
    state_t                 state_q, state_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   first_q, first_d;
    logic                   reload_q, reload_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;

    // One-entry TX holding buffer
    logic [DATA_WIDTH-1:0]  tx_buf_q, tx_buf_d;
    logic                   tx_full_q, tx_full_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic tx_load;

`ifdef SPI_SLAVE_SYNC_STATUS_EN
    logic [1:0] status_q, status_d;
    logic       rx_pend_q, rx_pend_d;
    logic       overrun_set, underrun_set;
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;
        sclk_rise   = sclk_s & ~sclk_hist_q;
        sclk_fall   = ~sclk_s & sclk_hist_q;
        cs_fall     = ~cs_s & cs_hist_q;
        cs_rise     = cs_s & ~cs_hist_q;
        lead_edge   = cpol_q ? sclk_fall : sclk_rise;
        trail_edge  = cpol_q ? sclk_rise : sclk_fall;
        sample_edge = cpha_q ? trail_edge : lead_edge;
        shift_edge  = cpha_q ? lead_edge : trail_edge;
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        bit_cnt_d  = bit_cnt_q;
        first_d    = first_q;
        reload_d   = reload_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    cpol_d    = CPOL;
                    cpha_d    = CPHA;
                    bit_cnt_d = '0;
                    first_d   = CPHA;
                    reload_d  = 1'b0;
                    tx_load   = 1'b1;
                end
            end
            ACTIVE: begin
                // cs rise beats a coincident sample edge; the partial byte is dropped
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    first_d    = 1'b0;
                    reload_d   = 1'b0;
                    tx_shift_d = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                            if (cpha_q) begin
                                tx_load = 1'b1;
                                first_d = 1'b1;
                            end else begin
                                reload_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    // CPHA=1 skips the first leading edge of each byte so the MSB holds
                    if (shift_edge) begin
                        if (first_q) begin
                            first_d = 1'b0;
                        end else if (reload_q) begin
                            reload_d = 1'b0;
                            tx_load  = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_load) begin
            tx_shift_d = tx_full_q ? tx_buf_q : '0;
        end
    end

    // Consumption and acceptance are exclusive: one needs a full buffer, the other an empty one
    always_comb begin
        tx_full_d = tx_full_q;
        tx_buf_d  = tx_buf_q;
        if (tx_load && tx_full_q) begin
            tx_full_d = 1'b0;
        end else if (tx_valid && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data;
        end
    end

`ifdef SPI_SLAVE_SYNC_STATUS_EN
    always_comb begin
        overrun_set  = rx_valid_d && rx_pend_q && !rx_ack;
        underrun_set = tx_load && !tx_full_q;
        rx_pend_d    = rx_pend_q;
        if (rx_valid_d) begin
            rx_pend_d = 1'b1;
        end else if (rx_ack) begin
            rx_pend_d = 1'b0;
        end
        status_d = (status_q & ~{2{status_clr}}) | {underrun_set, overrun_set};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            reload_q    <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
            status_q    <= '0;
            rx_pend_q   <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            reload_q    <= reload_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
            status_q    <= status_d;
            rx_pend_q   <= rx_pend_d;
`endif
        end
    end

    assign busy     = (state_q == ACTIVE);
    assign miso_oe  = (state_q == ACTIVE);
    assign miso_pin = (state_q == ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
    assign tx_ready = !tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    assign status   = status_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Randomized bench for spi_slave_sync: a pin-level SPI master, a TX feeder and a per-cycle output monitor.
`timescale 1ns/1ps
module tb_spi_slave_sync;
  localparam int S = 2;
  localparam int W = 8;

  // Clock / reset and DUT pins
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_pin = 1'b0, cs_pin = 1'b1, mosi_pin = 1'b0;
  logic cpol_in = 1'b0, cpha_in = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic miso_pin, miso_oe, tx_ready, rx_valid, busy;
  logic [W-1:0] rx_data;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
  logic [1:0] status;
  logic status_clr = 1'b0;
  logic rx_ack = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_slave_sync #(.SYNC_STAGES(S), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin),
    .miso_pin(miso_pin), .miso_oe(miso_oe), .CPOL(cpol_in), .CPHA(cpha_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    , .status(status), .status_clr(status_clr), .rx_ack(rx_ack)
`endif
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];    // bytes the slave must report on rx_valid, in order
  logic [W-1:0] feed_q[$];   // bytes waiting to be offered on tx_valid
  logic [W-1:0] m_mosi[4];
  logic [W-1:0] m_miso[4];
  logic [W-1:0] m_txl[4];
  int tx_len = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit hs_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // TX feeder: offers queued bytes with valid/ready; a byte is taken at the posedge where both are high
  initial begin : feeder
    forever begin
      @(negedge clk);
      if (hs_pending) begin
        tx_valid = 1'b0;
        hs_pending = 1'b0;
      end
      if (!tx_valid && feed_q.size() > 0) begin
        tx_data = feed_q.pop_front();
        tx_valid = 1'b1;
      end
      if (tx_valid && tx_ready) hs_pending = 1'b1;
    end
  end

`ifdef SPI_SLAVE_SYNC_STATUS_EN
  initial begin : acker
    forever begin
      @(negedge clk);
      rx_ack = rx_valid;
    end
  end
`endif

  task automatic wait_feed(input int budget);
    int t = 0;
    while ((feed_q.size() != 0 || tx_valid) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("feed_timeout", (feed_q.size() != 0 || tx_valid), 1'b0);
  endtask

  // Per-cycle monitor: busy follows settled cs, oe tracks busy, idle miso is low,
  // every rx_valid carries the next expected byte exactly S+1 cycles after the sampling sclk edge
  int sclk_age = 0, cs_age = 0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1;
  always @(posedge clk) begin
    #1;
    if (sclk_pin !== sclk_prev) sclk_age = 1; else sclk_age++;
    if (cs_pin !== cs_prev) cs_age = 1; else cs_age++;
    sclk_prev = sclk_pin;
    cs_prev = cs_pin;
    if (!rst) begin
      if (cs_age >= S + 2) check("busy_vs_cs", busy, !cs_pin);
      check("oe_vs_busy", miso_oe, busy);
      if (!miso_oe) check("miso_idle", miso_pin, 1'b0);
      if (rx_valid) begin
        check("rx_latency", sclk_age, S + 1);
        if (exp_q.size() == 0) check("rx_unexpected", rx_valid, 1'b0);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  // SPI master: nbytes bytes from m_mosi, the last one cut to last_bits bits; received bytes go to m_miso
  task automatic run_frame(input logic cpol, input logic cpha, input int nbytes,
                           input int last_bits, input int half, input bit rst_mid);
    logic [W-1:0] r;
    int nb;
    if (tx_len > 0) begin
      feed_q.push_back(m_txl[0]);
      wait_feed(200);
    end
    for (int k = 1; k < tx_len; k++) feed_q.push_back(m_txl[k]);
    cpol_in = cpol;
    cpha_in = cpha;
    sclk_pin = cpol;
    mosi_pin = 1'b0;
    wait_clks(S + 4);
    cs_pin = 1'b0;
    if (!cpha) mosi_pin = m_mosi[0][W-1];
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : W;
      r = '0;
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          wait_clks(half);
          r = {r[W-2:0], miso_pin};
          sclk_pin = ~sclk_pin;
          if (i == W - 1) exp_q.push_back(m_mosi[b]);
          wait_clks(half);
          sclk_pin = ~sclk_pin;
          if (i < nb - 1) mosi_pin = m_mosi[b][W-2-i];
          else if (b < nbytes - 1) mosi_pin = m_mosi[b+1][W-1];
          else mosi_pin = 1'b0;
        end else begin
          wait_clks(half);
          sclk_pin = ~sclk_pin;
          mosi_pin = m_mosi[b][W-1-i];
          wait_clks(half);
          r = {r[W-2:0], miso_pin};
          sclk_pin = ~sclk_pin;
          if (i == W - 1) exp_q.push_back(m_mosi[b]);
        end
      end
      m_miso[b] = r;
    end
    wait_clks(half);
    cs_pin = 1'b1;
    if (rst_mid) begin
      rst = 1'b1;
      wait_clks(1);
      rst = 1'b0;
    end else begin
      wait_clks(S + 4);
    end
  endtask

  // Model for the master side: byte k carries the k-th fed byte, or zeros once the feed runs dry
  task automatic check_master(input int nbytes);
    for (int b = 0; b < nbytes; b++)
      check("master_rx", m_miso[b], (b < tx_len) ? m_txl[b] : {W{1'b0}});
  endtask

  task automatic check_reset_values();
    check("rst_miso_pin", miso_pin, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, '0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
  endtask

  logic [W-1:0] last_full;
  logic [1:0] mode;
  int nbytes, half;

  initial begin : main
    rst = 1'b1;
    wait_clks(4);
    check_reset_values();
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    check("rst_status", status, 2'b00);
`endif
    rst = 1'b0;
    wait_clks(4);

    // Mode 0, clk/sclk ratio 8
    m_mosi[0] = 8'h5A; m_txl[0] = 8'hC3; tx_len = 1;
    run_frame(1'b0, 1'b0, 1, W, 4, 1'b0);
    check_master(1);
    check("m0_master_lit", m_miso[0], 8'hC3);
    check("m0_rx_data_lit", rx_data, 8'h5A);
    check("m0_tx_ready", tx_ready, 1'b1);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      m_mosi[0] = 8'h3C; m_txl[0] = 8'hA5; tx_len = 1;
      run_frame(m[1], m[0], 1, W, 4, 1'b0);
      check_master(1);
      check("mode_master_lit", m_miso[0], 8'hA5);
      check("mode_rx_data_lit", rx_data, 8'h3C);
    end

    // Three bytes in one frame, buffer refilled between bytes
    m_mosi[0] = 8'h01; m_mosi[1] = 8'h02; m_mosi[2] = 8'h03;
    m_txl[0] = 8'h10; m_txl[1] = 8'h20; m_txl[2] = 8'h30; tx_len = 3;
    run_frame(1'b0, 1'b0, 3, W, 5, 1'b0);
    check_master(3);
    check("multi_master_lit2", m_miso[2], 8'h30);
    check("multi_rx_data_lit", rx_data, 8'h03);

    // Empty TX buffer at cs fall
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    status_clr = 1'b1; wait_clks(1); status_clr = 1'b0; wait_clks(1);
    check("status_pre_clr", status, 2'b00);
`endif
    m_mosi[0] = 8'h96; tx_len = 0;
    run_frame(1'b0, 1'b0, 1, W, 4, 1'b0);
    check("underrun_master_lit", m_miso[0], 8'h00);
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    check("status_underrun", status, 2'b10);
    status_clr = 1'b1; wait_clks(1); status_clr = 1'b0;
    check("status_cleared", status, 2'b00);
`endif

    // Abort after 4 bits, then a full frame
    m_mosi[0] = 8'hFF; tx_len = 0;
    run_frame(1'b0, 1'b0, 1, 4, 4, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_oe", miso_oe, 1'b0);
    check("abort_rx_hold", rx_data, 8'h96);
    m_mosi[0] = 8'h81; m_txl[0] = 8'h42; tx_len = 1;
    run_frame(1'b0, 1'b0, 1, W, 4, 1'b0);
    check("after_abort_rx_lit", rx_data, 8'h81);
    check_master(1);

    // Reset mid-byte while the TX buffer holds a byte
    m_mosi[0] = 8'hE7; m_txl[0] = 8'h11; m_txl[1] = 8'h22; tx_len = 2;
    run_frame(1'b1, 1'b1, 1, 4, 5, 1'b1);
    check_reset_values();
    wait_clks(S + 4);
    m_mosi[0] = 8'h6B; m_txl[0] = 8'hD2; tx_len = 1;
    run_frame(1'b0, 1'b0, 1, W, 4, 1'b0);
    check_master(1);
    check("post_rst_rx_lit", rx_data, 8'h6B);

    // Random frames: mode, length, speed, data and feed depth
    for (int f = 0; f < 12; f++) begin
      mode = 2'($urandom_range(0, 3));
      nbytes = $urandom_range(1, 3);
      half = $urandom_range(4, 6);
      tx_len = $urandom_range(0, nbytes);
      for (int b = 0; b < 4; b++) begin
        m_mosi[b] = 8'($urandom);
        m_txl[b] = 8'($urandom);
      end
      last_full = m_mosi[nbytes-1];
      run_frame(mode[1], mode[0], nbytes, W, half, 1'b0);
      check_master(nbytes);
      check("rand_rx_last", rx_data, last_full);
    end

    wait_clks(20);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
